// File: rtl/pong_pkg.sv
// Shared types and fixed geometry for the pong engine.
package pong_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_MISS = 2'd2,
    S_OVER = 2'd3
  } state_t;

  // Direction encodings: dx=1 moves right, dy=1 moves down.
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic DIR_UP    = 1'b0;

  localparam logic [11:0] COL_BALL    = 12'hF00;
  localparam logic [11:0] COL_PAD     = 12'h0F0;
  localparam logic [11:0] COL_WALL    = 12'h00F;
  localparam logic [11:0] COL_BG      = 12'h000;
  localparam logic [11:0] COL_BG_OVER = 12'h400;

  localparam logic [9:0] VIS_W = 10'd640;
  localparam logic [9:0] VIS_H = 10'd480;

  localparam logic [9:0] WALL_X0 = 10'd32;
  localparam logic [9:0] WALL_X1 = 10'd35;
  localparam logic [9:0] PAD_X0  = 10'd600;
  localparam logic [9:0] PAD_X1  = 10'd603;

  // Ball bounces off the wall once its left edge is at or inside this column.
  localparam logic [9:0] WALL_BOUNCE_X = 10'd36;
  // Ball is lost once its left edge reaches this column (8 px from the right edge).
  localparam logic [9:0] MISS_X = 10'd632;

  localparam logic [9:0] PARK_X    = 10'd316;
  localparam logic [9:0] PARK_Y    = 10'd236;
  localparam logic [9:0] PAD_Y_RST = 10'd204;

  localparam logic [1:0] LIVES_INIT = 2'd3;

  function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pong_btn_sync.sv
// Two-flop synchroniser for a raw push button, plus a rising-edge pulse.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Synchroniser chain and one extra flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;

endmodule

// File: rtl/pong_engine.sv
// Single-player pong: paddle, ball, lives/hits bookkeeping and pixel colour.
//
// state | meaning
// IDLE  | ball parked, waiting for a start press
// PLAY  | ball moving, bounces and paddle hits resolved each frame
// MISS  | ball frozen for MISS_WAIT frames after passing the paddle
// OVER  | no lives left, red background, waiting for a start press
module pong_engine
  import pong_pkg::*;
#(
  parameter int BALL_SZ   = 8,
  parameter int PAD_H     = 72,
  parameter int PAD_SPD   = 4,
  parameter int BALL_V    = 2,
  parameter int MISS_WAIT = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        select,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        video_on,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_start,
  output logic [11:0] rgb,
  output logic [7:0]  hits,
  output logic [1:0]  lives,
  output logic        game_over
);

  localparam logic [9:0] SZ     = 10'(BALL_SZ);
  localparam logic [9:0] PH     = 10'(PAD_H);
  localparam logic [9:0] PS     = 10'(PAD_SPD);
  localparam logic [9:0] BV     = 10'(BALL_V);
  localparam logic [9:0] PY_MAX = VIS_H - PH;
  localparam int         MW     = (MISS_WAIT > 1) ? $clog2(MISS_WAIT + 1) : 1;
  localparam logic [MW-1:0] MISS_LOAD = MW'(MISS_WAIT);
  localparam logic [MW-1:0] MISS_LAST = MW'(1);

  logic up_lvl, up_rise, down_lvl, down_rise, start_lvl, start_rise;
  logic unused_sync;

  btn_sync u_sync_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_up),
    .level (up_lvl),
    .rise  (up_rise)
  );

  btn_sync u_sync_down (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_down),
    .level (down_lvl),
    .rise  (down_rise)
  );

  btn_sync u_sync_start (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_start),
    .level (start_lvl),
    .rise  (start_rise)
  );

  assign unused_sync = up_rise ^ down_rise ^ start_lvl;

  state_t        state, state_nx;
  logic [9:0]    bx, bx_nx, by, by_nx, py, py_nx;
  logic          dx, dx_nx, dy, dy_nx;
  logic [1:0]    lives_nx;
  logic [7:0]    hits_nx;
  logic [MW-1:0] miss_cnt, miss_cnt_nx;
  logic          frame_tick;
  logic          start_pend;
  logic          dx_b, dy_b;
  logic [9:0]    bx_far, by_far;
  logic          pad_hit;
  logic          ball_px, pad_px, wall_px;

  assign bx_far = bx + SZ;
  assign by_far = by + SZ;

  // One frame tick per frame, at the first pixel after the visible area.
  always_ff @(posedge clk) begin
    if (rst) frame_tick <= 1'b0;
    else     frame_tick <= select && (hcount == '0) && (vcount == VIS_H);
  end

  // A start edge may arrive anywhere in the frame; hold it until the next tick.
  always_ff @(posedge clk) begin
    if (rst) start_pend <= 1'b0;
    else     start_pend <= (start_pend & ~frame_tick) | start_rise;
  end

  assign pad_hit = (dx == DIR_RIGHT) && in_range(bx_far, PAD_X0, PAD_X1) &&
                   (by_far > py) && (by < py + PH);

  // Game state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bx       <= PARK_X;
      by       <= PARK_Y;
      dx       <= DIR_RIGHT;
      dy       <= DIR_DOWN;
      py       <= PAD_Y_RST;
      lives    <= LIVES_INIT;
      hits     <= '0;
      miss_cnt <= '0;
    end else begin
      state    <= state_nx;
      bx       <= bx_nx;
      by       <= by_nx;
      dx       <= dx_nx;
      dy       <= dy_nx;
      py       <= py_nx;
      lives    <= lives_nx;
      hits     <= hits_nx;
      miss_cnt <= miss_cnt_nx;
    end
  end

  // Per-frame update: paddle motion, FSM transitions, ball physics.
  always_comb begin
    state_nx    = state;
    bx_nx       = bx;
    by_nx       = by;
    dx_nx       = dx;
    dy_nx       = dy;
    py_nx       = py;
    lives_nx    = lives;
    hits_nx     = hits;
    miss_cnt_nx = miss_cnt;
    dx_b        = dx;
    dy_b        = dy;

    if (frame_tick) begin
      if (state != S_OVER) begin
        if (up_lvl && !down_lvl) begin
          py_nx = (py >= PS) ? py - PS : '0;
        end else if (down_lvl && !up_lvl) begin
          py_nx = (py + PS >= PY_MAX) ? PY_MAX : py + PS;
        end
      end

      case (state)
        S_IDLE: begin
          if (start_pend) state_nx = S_PLAY;
        end
        S_PLAY: begin
          if (bx >= MISS_X) begin
            lives_nx    = lives - 2'd1;
            miss_cnt_nx = MISS_LOAD;
            state_nx    = S_MISS;
          end else begin
            if (by <= BV)            dy_b = DIR_DOWN;
            if (by_far >= VIS_H - BV) dy_b = DIR_UP;
            if (bx <= WALL_BOUNCE_X) dx_b = DIR_RIGHT;
            if (pad_hit) begin
              dx_b = DIR_LEFT;
              if (hits != 8'hFF) hits_nx = hits + 8'd1;
            end
            dx_nx = dx_b;
            dy_nx = dy_b;
            bx_nx = (dx_b == DIR_RIGHT) ? bx + BV : bx - BV;
            by_nx = (dy_b == DIR_DOWN)  ? by + BV : by - BV;
          end
        end
        S_MISS: begin
          if (miss_cnt == MISS_LAST) begin
            miss_cnt_nx = '0;
            if (lives == 2'd0) begin
              state_nx = S_OVER;
            end else begin
              bx_nx    = PARK_X;
              by_nx    = PARK_Y;
              dx_nx    = DIR_RIGHT;
              dy_nx    = DIR_DOWN;
              state_nx = S_PLAY;
            end
          end else begin
            miss_cnt_nx = miss_cnt - MISS_LAST;
          end
        end
        S_OVER: begin
          if (start_pend) begin
            lives_nx = LIVES_INIT;
            hits_nx  = '0;
            bx_nx    = PARK_X;
            by_nx    = PARK_Y;
            dx_nx    = DIR_RIGHT;
            dy_nx    = DIR_DOWN;
            state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign game_over = (state == S_OVER);

  assign ball_px = (state != S_OVER) && (hcount >= bx) && (hcount < bx_far) &&
                   (vcount >= by) && (vcount < by_far);
  assign pad_px  = in_range(hcount, PAD_X0, PAD_X1) && (vcount >= py) && (vcount < py + PH);
  assign wall_px = in_range(hcount, WALL_X0, WALL_X1);

  // Pixel colour, registered so it lines up with the registered syncs.
  always_ff @(posedge clk) begin
    if (rst)              rgb <= COL_BG;
    else if (!video_on)   rgb <= COL_BG;
    else if (ball_px)     rgb <= COL_BALL;
    else if (pad_px)      rgb <= COL_PAD;
    else if (wall_px)     rgb <= COL_WALL;
    else if (game_over)   rgb <= COL_BG_OVER;
    else                  rgb <= COL_BG;
  end

endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: pixel vector table, frame-level reference model,
// randomized paddle/start stimulus and scripted corner-case sequences.
module tb_pong_engine;
  import pong_pkg::*;

  localparam int BSZ = 8, PH = 72, PS = 4, BV = 2, MW = 60;

  logic        clk = 1'b0;
  logic        rst, select, video_on, btn_up, btn_down, btn_start;
  logic [9:0]  hcount, vcount;
  logic [11:0] rgb;
  logic [7:0]  hits;
  logic [1:0]  lives;
  logic        game_over;

  pong_engine #(.BALL_SZ(BSZ), .PAD_H(PH), .PAD_SPD(PS), .BALL_V(BV), .MISS_WAIT(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .select    (select),
    .hcount    (hcount),
    .vcount    (vcount),
    .video_on  (video_on),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_start (btn_start),
    .rgb       (rgb),
    .hits      (hits),
    .lives     (lives),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: ball as position + signed velocity.
  typedef enum int {M_IDLE = 0, M_PLAY = 1, M_MISS = 2, M_OVER = 3} mstate_t;
  mstate_t m_st;
  int m_x, m_y, m_vx, m_vy, m_py, m_lives, m_hits, m_wait;
  bit m_pend;

  typedef struct {
    int h;
    int v;
    bit von;
    int exp;
  } pix_t;
  pix_t pix [13];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dut_state();
    case (dut.state)
      S_IDLE:  return 0;
      S_PLAY:  return 1;
      S_MISS:  return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_park();
    m_x = 316; m_y = 236; m_vx = BV; m_vy = BV;
  endtask

  task automatic model_reset();
    m_st = M_IDLE; model_park(); m_py = 204; m_lives = 3; m_hits = 0; m_wait = 0; m_pend = 0;
  endtask

  task automatic model_tick();
    int old_py;
    old_py = m_py;
    if (m_st != M_OVER) begin
      if (btn_up && !btn_down)      m_py = (m_py - PS < 0) ? 0 : m_py - PS;
      else if (btn_down && !btn_up) m_py = (m_py + PS > 480 - PH) ? 480 - PH : m_py + PS;
    end
    case (m_st)
      M_IDLE: if (m_pend) m_st = M_PLAY;
      M_PLAY: begin
        if (m_x >= 632) begin
          m_lives--; m_wait = MW; m_st = M_MISS;
        end else begin
          if (m_y <= BV) m_vy = BV;
          if (m_y + BSZ >= 480 - BV) m_vy = -BV;
          if (m_x <= 36) m_vx = BV;
          if (m_vx > 0 && m_x + BSZ >= 600 && m_x + BSZ <= 603 &&
              m_y + BSZ > old_py && m_y < old_py + PH) begin
            m_vx = -BV;
            if (m_hits < 255) m_hits++;
          end
          m_x += m_vx; m_y += m_vy;
        end
      end
      M_MISS: begin
        m_wait--;
        if (m_wait == 0) begin
          if (m_lives == 0) m_st = M_OVER;
          else begin model_park(); m_st = M_PLAY; end
        end
      end
      M_OVER: if (m_pend) begin
        m_lives = 3; m_hits = 0; model_park(); m_st = M_IDLE;
      end
      default: ;
    endcase
    m_pend = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, dut_state(), int'(m_st));
    check({tag, ".bx"}, int'(dut.bx), m_x);
    check({tag, ".by"}, int'(dut.by), m_y);
    check({tag, ".dx"}, int'(dut.dx), (m_vx > 0) ? 1 : 0);
    check({tag, ".dy"}, int'(dut.dy), (m_vy > 0) ? 1 : 0);
    check({tag, ".py"}, int'(dut.py), m_py);
    check({tag, ".lives"}, int'(lives), m_lives);
    check({tag, ".hits"}, int'(hits), m_hits);
    check({tag, ".game_over"}, int'(game_over), (m_st == M_OVER) ? 1 : 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".rgb"}, int'(rgb), 0);
    check({tag, ".lives"}, int'(lives), 3);
    check({tag, ".hits"}, int'(hits), 0);
    check({tag, ".py"}, int'(dut.py), 204);
    check({tag, ".bx"}, int'(dut.bx), 316);
    check({tag, ".by"}, int'(dut.by), 236);
    check({tag, ".state"}, dut_state(), 0);
    check({tag, ".game_over"}, int'(game_over), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Frame tick strobe; buttons settle through the synchroniser first.
  task automatic frame();
    repeat (3) @(negedge clk);
    select = 1'b1; hcount = 10'd0; vcount = 10'd480;
    @(negedge clk);
    select = 1'b0; vcount = 10'd0;
    @(negedge clk);
    model_tick();
  endtask

  // Reset lands on the edge that would have applied the frame update.
  task automatic reset_mid_tick();
    repeat (3) @(negedge clk);
    select = 1'b1; hcount = 10'd0; vcount = 10'd480;
    @(negedge clk);
    select = 1'b0; vcount = 10'd0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic pulse_start();
    @(negedge clk); btn_start = 1'b1;
    @(negedge clk); btn_start = 1'b0;
    m_pend = 1;
  endtask

  task automatic pixel_check(input string nm, input int h, input int v, input bit von,
                             input int exp);
    @(negedge clk); hcount = 10'(h); vcount = 10'(v); video_on = von;
    @(negedge clk); check(nm, int'(rgb), exp);
    video_on = 1'b0; hcount = 10'd0; vcount = 10'd0;
  endtask

  initial begin
    int n, miss_run, pre_x, pre_vx, misses;
    bit saw_hit;

    pix[0]  = '{320, 240, 1'b1, 12'hF00};
    pix[1]  = '{320, 240, 1'b0, 12'h000};
    pix[2]  = '{316, 236, 1'b1, 12'hF00};
    pix[3]  = '{323, 243, 1'b1, 12'hF00};
    pix[4]  = '{324, 243, 1'b1, 12'h000};
    pix[5]  = '{601, 210, 1'b1, 12'h0F0};
    pix[6]  = '{600, 204, 1'b1, 12'h0F0};
    pix[7]  = '{603, 275, 1'b1, 12'h0F0};
    pix[8]  = '{603, 276, 1'b1, 12'h000};
    pix[9]  = '{601, 100, 1'b1, 12'h000};
    pix[10] = '{33, 100, 1'b1, 12'h00F};
    pix[11] = '{35, 479, 1'b1, 12'h00F};
    pix[12] = '{36, 0, 1'b1, 12'h000};

    rst = 1'b0; select = 1'b0; hcount = '0; vcount = '0; video_on = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0;

    do_reset();
    check_reset_vals("reset");

    for (int i = 0; i < 13; i++)
      pixel_check($sformatf("pix%0d", i), pix[i].h, pix[i].v, pix[i].von, pix[i].exp);

    btn_up = 1'b1;
    for (int i = 0; i < 60; i++) begin
      frame();
      check("clamp_up.py", int'(dut.py), m_py);
    end
    check("clamp_floor", int'(dut.py), 0);
    btn_down = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame();
      check_all("both_btn");
    end
    check("both_hold", int'(dut.py), 0);

    for (int i = 0; i < 20; i++) begin
      btn_up = 1'($urandom_range(0, 1)); btn_down = 1'($urandom_range(0, 1));
      frame();
      check_all("rand_idle");
    end

    btn_up = 1'b0; btn_down = 1'b1; n = 0;
    while (m_py != 480 - PH && n < 200) begin frame(); check_all("to_bottom"); n++; end
    check("clamp_ceiling", int'(dut.py), 480 - PH);

    pulse_start();
    frame();
    check_all("launch");
    check("launch.state", dut_state(), 1);

    saw_hit = 0; n = 0;
    while (!saw_hit && n < 400) begin
      pre_x = m_x; pre_vx = m_vx;
      frame();
      check_all("to_hit");
      if (pre_x == 592 && pre_vx > 0) begin
        saw_hit = 1;
        check("hit.dx_left", int'(dut.dx), 0);
        check("hit.count", int'(hits), 1);
      end
      n++;
    end
    check("hit_reached", int'(saw_hit), 1);

    for (int i = 0; i < 200; i++) begin
      btn_up = 1'($urandom_range(0, 1)); btn_down = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) pulse_start();
      frame();
      check_all("rand_play");
    end

    btn_up = 1'b0; btn_down = 1'b0;
    reset_mid_tick();
    check_reset_vals("reset_mid_frame");

    btn_up = 1'b1;
    pulse_start();
    frame();
    check_all("relaunch");
    miss_run = 0; misses = 0; n = 0;
    while (m_st != M_OVER && n < 3000) begin
      frame();
      check_all("to_over");
      if (dut.state == S_MISS) miss_run++;
      else if (miss_run > 0) begin
        check("miss_frames", miss_run, MW);
        miss_run = 0; misses++;
      end
      n++;
    end
    if (miss_run > 0) begin check("miss_frames", miss_run, MW); misses++; end
    check("misses", misses, 3);
    check("over.lives", int'(lives), 0);
    check("over.game_over", int'(game_over), 1);
    pixel_check("over.bg", 100, 100, 1'b1, 12'h400);
    pixel_check("over.no_ball", m_x + 1, m_y + 1, 1'b1, 12'h400);
    pixel_check("over.blank", 100, 100, 1'b0, 12'h000);

    btn_up = 1'b0; btn_down = 1'b1;
    for (int i = 0; i < 3; i++) begin frame(); check_all("over_frozen"); end
    btn_down = 1'b0;

    @(negedge clk); btn_start = 1'b1; m_pend = 1;
    frame();
    check_all("restart");
    check("restart.lives", int'(lives), 3);
    check("restart.hits", int'(hits), 0);
    for (int i = 0; i < 4; i++) begin frame(); check_all("start_held"); end
    check("no_retrigger", dut_state(), 0);
    btn_start = 1'b0;

    btn_up = 1'b1;
    pulse_start();
    frame();
    n = 0;
    while (m_st != M_MISS && n < 400) begin frame(); check_all("to_miss"); n++; end
    for (int i = 0; i < 10; i++) begin frame(); check_all("in_miss"); end
    check("in_miss.state", dut_state(), 2);
    btn_up = 1'b0;
    reset_mid_tick();
    check_reset_vals("reset_mid_miss");
    frame();
    check_all("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
